// File: rtl/sobel_pkg.sv
// sobel_pkg: shared types for the Sobel window scan controller
//   dir_t   - shift direction driven on shift_direc
//   state_t - scan controller FSM states
package sobel_pkg;
    typedef enum logic [1:0] {
        NONE  = 2'b00,
        LEFT  = 2'b01,
        RIGHT = 2'b10,
        UP    = 2'b11
    } dir_t;
    typedef enum logic [3:0] {
        IDLE, FILL_REQ, FILL_WAIT, EMIT, SHIFT_REQ, SHIFT_WAIT, COL_REQ, COL_WAIT, DONE
    } state_t;
endpackage

// File: rtl/scan_addr_gen.sv
// scan_addr_gen: pixel address and window slot for the current read
//   row, col   - registered window centre
//   dir        - direction of the last shift (selects the new column/row)
//   fill       - full 9-pixel fill instead of a 3-pixel column/row refresh
//   idx        - read index within the fill (0..8) or refresh (0..2)
//   pixel_addr - raster address row*IMG_W+col of the pixel to read
//   slot_idx   - target window slot 3*dr+dc
module scan_addr_gen import sobel_pkg::*; #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    localparam int ADDR_W = $clog2(IMG_W * IMG_H),
    localparam int RW = $clog2(IMG_H),
    localparam int CW = $clog2(IMG_W)
) (
    input  logic [RW-1:0]     row,
    input  logic [CW-1:0]     col,
    input  dir_t              dir,
    input  logic              fill,
    input  logic [3:0]        idx,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic [3:0]        slot_idx
);
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
    logic [1:0] dr, dc;
    // Offsets from the window's top-left corner; a refresh touches one edge of the window.
    always_comb begin
        dr = fill ? 2'(idx / 4'd3) : dir == UP ? 2'd2 : idx[1:0];
        dc = fill ? 2'(idx % 4'd3) : dir == LEFT ? 2'd2 : dir == RIGHT ? 2'd0 : idx[1:0];
    end
    assign pixel_addr = (ADDR_W'(row) + ADDR_W'(dr) - ONE) * ADDR_W'(IMG_W) + ADDR_W'(col) + ADDR_W'(dc) - ONE;
    assign slot_idx   = {2'b00, dr} * 4'd3 + {2'b00, dc};
endmodule

// File: rtl/window_scan_ctrl.sv
// window_scan_ctrl: serpentine 3x3 window scan over an IMG_W x IMG_H frame
//   clk, rst                          - clock, asynchronous active-high reset
//   start                             - begin a frame scan (only seen in IDLE)
//   read_done, shift_done, proc_done  - acks from window buffer and Sobel stage
//   start_read, pixel_addr, slot_idx  - one-cycle pixel read request
//   start_shift, shift_direc          - one-cycle window shift request
//   window_valid, win_row, win_col    - complete window and its centre
//   busy, frame_done                  - not idle / end-of-frame pulse
module window_scan_ctrl import sobel_pkg::*; #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    localparam int ADDR_W = $clog2(IMG_W * IMG_H),
    localparam int RW = $clog2(IMG_H),
    localparam int CW = $clog2(IMG_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              read_done,
    input  logic              shift_done,
    input  logic              proc_done,
    output logic              start_read,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic [3:0]        slot_idx,
    output logic              start_shift,
    output logic [1:0]        shift_direc,
    output logic              window_valid,
    output logic [RW-1:0]     win_row,
    output logic [CW-1:0]     win_col,
    output logic              busy,
    output logic              frame_done
);
    state_t state, state_nx;
    dir_t dir, dir_nx;
    logic [3:0] cnt;
    logic row_end, last_win;
    logic [ADDR_W-1:0] addr;
    logic [3:0] slot;

    // Rows with odd centre index (row-1 even) travel right, the others travel left.
    assign row_end  = win_row[0] ? win_col == CW'(IMG_W - 2) : win_col == CW'(1);
    assign last_win = row_end && win_row == RW'(IMG_H - 2);
    assign dir_nx   = row_end ? UP : win_row[0] ? LEFT : RIGHT;

    scan_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_addr (
        .row(win_row), .col(win_col), .dir(dir), .fill(state == FILL_REQ),
        .idx(cnt), .pixel_addr(addr), .slot_idx(slot)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            win_row <= RW'(1);
            win_col <= CW'(1);
            cnt     <= '0;
            dir     <= NONE;
        end else begin
            if (state == IDLE && start) begin
                win_row <= RW'(1);
                win_col <= CW'(1);
                cnt     <= '0;
            end
            if ((state == FILL_WAIT || state == COL_WAIT) && read_done)
                cnt <= state_nx == EMIT ? 4'd0 : cnt + 4'd1;
            if (state == EMIT && proc_done) dir <= dir_nx;
            if (state == SHIFT_WAIT && shift_done) begin
                win_col <= dir == LEFT ? win_col + CW'(1) : dir == RIGHT ? win_col - CW'(1) : win_col;
                win_row <= dir == UP ? win_row + RW'(1) : win_row;
            end
        end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       if (start) state_nx = FILL_REQ;
            FILL_REQ:   state_nx = FILL_WAIT;
            FILL_WAIT:  if (read_done) state_nx = cnt == 4'd8 ? EMIT : FILL_REQ;
            EMIT:       if (proc_done) state_nx = last_win ? DONE : SHIFT_REQ;
            SHIFT_REQ:  state_nx = SHIFT_WAIT;
            SHIFT_WAIT: if (shift_done) state_nx = COL_REQ;
            COL_REQ:    state_nx = COL_WAIT;
            COL_WAIT:   if (read_done) state_nx = cnt == 4'd2 ? EMIT : COL_REQ;
            DONE:       state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    // Address and slot are forced to zero outside a read so idle/reset outputs are clean.
    always_comb begin
        start_read   = state == FILL_REQ || state == COL_REQ;
        start_shift  = state == SHIFT_REQ;
        shift_direc  = state == SHIFT_REQ ? dir : NONE;
        window_valid = state == EMIT;
        busy         = state != IDLE;
        frame_done   = state == DONE;
        pixel_addr   = start_read ? addr : '0;
        slot_idx     = start_read ? slot : '0;
    end
endmodule

// File: tb/tb_window_scan_ctrl.sv
// tb_window_scan_ctrl: scoreboard bench for a 5x4 and a 3x3 scan controller
module tb_window_scan_ctrl;
    typedef struct packed {
        logic       inst;
        logic [2:0] kind;
        logic [7:0] a;
        logic [7:0] b;
    } ev_t;
    localparam logic [2:0] K_READ = 3'd0, K_SHIFT = 3'd1, K_WIN = 3'd2, K_LEN = 3'd3, K_FRAME = 3'd4;

    logic clk = 1'b0, rst = 1'b0;
    logic [1:0] start = '0, read_done = '0, shift_done = '0, proc_done = '0;
    logic [1:0] start_read, start_shift, window_valid, busy, frame_done;
    logic [4:0] a_addr;
    logic [3:0] b_addr;
    logic [1:0] a_row, b_row, b_col;
    logic [2:0] a_col;
    logic [3:0] slot [2];
    logic [1:0] direc [2];
    logic [7:0] addr [2], row [2], col [2];

    assign addr[0] = 8'(a_addr);
    assign addr[1] = 8'(b_addr);
    assign row[0]  = 8'(a_row);
    assign row[1]  = 8'(b_row);
    assign col[0]  = 8'(a_col);
    assign col[1]  = 8'(b_col);

    always #5 clk = ~clk;

    window_scan_ctrl #(.IMG_W(5), .IMG_H(4)) dut_a (
        .clk(clk), .rst(rst), .start(start[0]), .read_done(read_done[0]),
        .shift_done(shift_done[0]), .proc_done(proc_done[0]), .start_read(start_read[0]),
        .pixel_addr(a_addr), .slot_idx(slot[0]), .start_shift(start_shift[0]),
        .shift_direc(direc[0]), .window_valid(window_valid[0]), .win_row(a_row),
        .win_col(a_col), .busy(busy[0]), .frame_done(frame_done[0])
    );

    window_scan_ctrl #(.IMG_W(3), .IMG_H(3)) dut_b (
        .clk(clk), .rst(rst), .start(start[1]), .read_done(read_done[1]),
        .shift_done(shift_done[1]), .proc_done(proc_done[1]), .start_read(start_read[1]),
        .pixel_addr(b_addr), .slot_idx(slot[1]), .start_shift(start_shift[1]),
        .shift_direc(direc[1]), .window_valid(window_valid[1]), .win_row(b_row),
        .win_col(b_col), .busy(busy[1]), .frame_done(frame_done[1])
    );

    ev_t q[$];
    int vectors = 0, miscompares = 0;

    // Hand-computed 5x4 scan: fill, then column/row refreshes per shift.
    int rd_a [24] = '{0, 1, 2, 5, 6, 7, 10, 11, 12, 3, 8, 13, 4, 9, 14, 17, 18, 19, 6, 11, 16, 5, 10, 15};
    int rd_s [24] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 2, 5, 8, 2, 5, 8, 6, 7, 8, 0, 3, 6, 0, 3, 6};
    int wr [6] = '{1, 1, 1, 2, 2, 2};
    int wc [6] = '{1, 2, 3, 3, 2, 1};
    int sd [5] = '{1, 1, 3, 2, 2};

    function automatic void push(input logic inst, input logic [2:0] k, input int a, input int b);
        q.push_back({inst, k, 8'(a), 8'(b)});
    endfunction

    function automatic void push_frame_a(input int h);
        int k = 0;
        for (int w = 0; w < 6; w++) begin
            for (int j = 0; j < (w == 0 ? 9 : 3); j++) begin
                push(1'b0, K_READ, rd_a[k], rd_s[k]);
                k++;
            end
            push(1'b0, K_WIN, wr[w], wc[w]);
            push(1'b0, K_LEN, w == 0 ? h : 1, 0);
            if (w < 5) push(1'b0, K_SHIFT, sd[w], 0);
            else push(1'b0, K_FRAME, 0, 0);
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic score(input ev_t got);
        ev_t exp;
        vectors++;
        if (q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event inst=%0d kind=%0d a=%0d b=%0d (nothing expected)",
                     got.inst, got.kind, got.a, got.b);
        end else begin
            exp = q.pop_front();
            if (exp !== got) begin
                miscompares++;
                $display("FAIL event got inst=%0d kind=%0d a=%0d b=%0d expected inst=%0d kind=%0d a=%0d b=%0d",
                         got.inst, got.kind, got.a, got.b, exp.inst, exp.kind, exp.a, exp.b);
            end
        end
    endtask

    // Buffer/Sobel model: acks each request one cycle after seeing it, optional spurious acks.
    logic [1:0] rd_pend = '0, sh_pend = '0;
    int pc [2] = '{0, 0};
    int hold [2] = '{1, 1};
    logic spur = 1'b0;
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                rd_pend[i] = 1'b0;
                sh_pend[i] = 1'b0;
                pc[i] = 0;
                read_done[i] = 1'b0;
                shift_done[i] = 1'b0;
                proc_done[i] = 1'b0;
            end else begin
                read_done[i] = rd_pend[i] | (spur & sh_pend[i]);
                shift_done[i] = sh_pend[i] | (spur & rd_pend[i]);
                rd_pend[i] = start_read[i];
                sh_pend[i] = start_shift[i];
                if (window_valid[i]) pc[i]++;
                else if (pc[i] > 0) begin
                    pc[i] = 0;
                    hold[i] = 1;
                end
                proc_done[i] = window_valid[i] && pc[i] >= hold[i];
            end
        end
    end

    // Monitor: turns DUT activity into events and checks them against the queue.
    logic [1:0] wv_prev = '0;
    int len [2] = '{0, 0};
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                wv_prev[i] = 1'b0;
                len[i] = 0;
            end else begin
                if (!window_valid[i] && wv_prev[i]) begin
                    score({i[0], K_LEN, 8'(len[i]), 8'd0});
                    len[i] = 0;
                end
                if (window_valid[i] && !wv_prev[i]) score({i[0], K_WIN, row[i], col[i]});
                if (window_valid[i]) len[i]++;
                if (start_read[i]) score({i[0], K_READ, addr[i], {4'd0, slot[i]}});
                if (start_shift[i]) score({i[0], K_SHIFT, {6'd0, direc[i]}, 8'd0});
                if (frame_done[i]) score({i[0], K_FRAME, 8'd0, 8'd0});
                if (start_read[i] && start_shift[i]) chk("read_shift_overlap", 1, 0);
                wv_prev[i] = window_valid[i];
            end
        end
    end

    task automatic reset_check(input int i, input string name);
        chk({name, "_ctrl"}, 32'({start_read[i], start_shift[i], window_valid[i], busy[i], frame_done[i], direc[i]}), 32'd0);
        chk({name, "_data"}, 32'({addr[i], slot[i], row[i], col[i]}), 32'({8'd0, 4'd0, 8'd1, 8'd1}));
    endtask

    task automatic run_frame(input int i, input int spur_at);
        bit seen = 1'b0;
        @(negedge clk);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
        chk("busy_after_start", 32'(busy[i]), 32'd1);
        for (int n = 0; n < 1000 && !seen; n++) begin
            @(negedge clk);
            start[i] = n == spur_at;
            seen = frame_done[i];
        end
        start[i] = 1'b0;
        chk("frame_done_seen", 32'(seen), 32'd1);
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("idle_after_frame", 32'(busy[i]), 32'd0);
    endtask

    initial begin
        bit seen, sh;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        reset_check(0, "reset_a");
        reset_check(1, "reset_b");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Frame 1: first window held 20 cycles, spurious acks, mid-frame start pulse.
        spur = 1'b1;
        hold[0] = 20;
        push_frame_a(20);
        run_frame(0, 30);
        spur = 1'b0;

        // Frame 2: abort with reset while waiting on the first column read.
        push_frame_a(1);
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        seen = 1'b0;
        sh = 1'b0;
        for (int n = 0; n < 500 && !seen; n++) begin
            @(negedge clk);
            if (start_shift[0]) sh = 1'b1;
            seen = sh && start_read[0];
        end
        chk("col_req_reached", 32'(seen), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 reset_check(0, "abort_reset");
        q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_after_abort", 32'({busy[0], start_read[0], start_shift[0]}), 32'd0);

        // Frame 3: fresh full frame after the abort.
        push_frame_a(1);
        run_frame(0, -1);

        // 3x3 image: single window, no shifts.
        for (int k = 0; k < 9; k++) push(1'b1, K_READ, k, k);
        push(1'b1, K_WIN, 1, 1);
        push(1'b1, K_LEN, 1, 0);
        push(1'b1, K_FRAME, 0, 0);
        run_frame(1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
